serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//   Parallel-to-serial stage directly upstream of the deserializer. Accepts
//   DATA_WIDTH-bit words on a valid/ready handshake and drives them out one bit
//   per clk on data_out. Words go out back-to-back with no idle gap, so the
//   deserializer sees a continuous bit stream.
//   frame_start marks the first bit of each word for word alignment.
// PARAMETERS
//   DATA_WIDTH  32  word width in bits; legal range 2..64
//   MSB_FIRST   1   1: bit DATA_WIDTH-1 goes out first; 0: bit 0 goes out first
// PORTS
//   clk          in   1           single clock, all logic on rising edge
//   rst          in   1           synchronous reset, active-high
//   din          in   DATA_WIDTH  parallel word to send
//   din_valid    in   1           din holds a valid word
//   din_ready    out  1           block can take a word this cycle
//   data_out     out  1           serial bit stream to the deserializer data_in
//   frame_start  out  1           high during the first bit of each word
//   busy         out  1           a word is being shifted out
// BEHAVIOUR
//   Reset: clk plus synchronous active-high rst; all state clears on an edge with rst=1.
//   - Reset values: data_out=0, frame_start=0, busy=0, din_ready=1.
//   - Reset clears the shift register, the bit counter and the holding register.
//   Storage: shift register sr, bit counter cnt (0..DATA_WIDTH-1), one-word
//     holding register hold plus hold_full flag.
//   Handshake:
//   - Transfer happens at a rising edge where din_valid && din_ready.
//   - din_ready = !hold_full, combinational from registered state only.
//   - din is sampled only on a transfer edge.
//   FSM states:
//   - IDLE: data_out=0, frame_start=0, busy=0.
//     - On a transfer, din loads straight into sr, cnt=0, and the state goes to SHIFT.
//     - The first bit appears on data_out in the cycle after the transfer edge (latency 1).
//   - SHIFT: busy=1. data_out is the current bit of sr, and frame_start=(cnt==0).
//     - Each edge advances cnt and shifts sr (left if MSB_FIRST, else right).
//     - A transfer in SHIFT writes din into hold and sets hold_full.
//   - Last bit (cnt==DATA_WIDTH-1):
//     - If hold_full: load sr from hold, clear hold_full, cnt=0, stay in SHIFT.
//     - Else, if a transfer occurs on this same edge: load sr directly from din, cnt=0, stay in SHIFT.
//     - Else: go to IDLE, and data_out=0 from the next cycle.
//     - In both load cases there is zero gap between words.
//   Boundaries:
//   - hold_full deasserts din_ready. No word is ever dropped or overwritten.
//   - din_valid may drop without a transfer. It has no effect.
//   - Simultaneous last-bit and transfer with hold_full=1:
//     - hold moves into sr.
//     - The incoming word is not taken, because din_ready=0 in that cycle.
//   - rst during SHIFT aborts the word: data_out=0 the next cycle, hold discarded.
//   - cnt wraps exactly at DATA_WIDTH-1 and never exceeds it.
//   - Throughput: one word per DATA_WIDTH cycles when din_valid is held high.
// TESTING
//   1. Reset check: assert rst for 2 cycles, with din_valid=1 during reset.
//      -> data_out=0, busy=0, din_ready=1, and no transfer is accepted.
//   2. Single word: din=32'h0122_4555, valid for 1 cycle, MSB_FIRST=1.
//      -> bits 0000_0001_0010_0010_0100_0101_0101_0101 go out on data_out over 32 cycles.
//      -> frame_start=1 only on the first bit; IDLE and data_out=0 after that.
//   3. Back-to-back: 32'h0122_4555, then 32'hCDEF_CDEF, then 32'hEDE1_87AF, din_valid held high.
//      -> 96 contiguous bits with no gap; frame_start pulses at bits 0, 32 and 64.
//      -> Through a loopback deserializer, each word is recovered exactly.
//   4. Backpressure: hold_full=1 during word 1.
//      -> din_ready=0, and din changes have no effect until word 2 moves from hold to sr.
//   5. Mid-word reset: rst at bit 10 of 32'hCDEF_CDEF with hold_full=1.
//      -> data_out=0 and din_ready=1 next cycle; no residual bits after reset.
//   6. MSB_FIRST=0 with din=32'h0000_0001.
//      -> data_out=1 on the first bit only, then 31 zeros.

Source files
------------

// File: rtl/serializer.sv
// Parallel-to-serial stage: takes DATA_WIDTH-bit words on valid/ready and shifts them out
// one bit per clock, back-to-back, with a one-word holding register for zero-gap streaming.
module serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  data_out,
  output logic                  frame_start,
  output logic                  busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]            r_state;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [CntW-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;

  logic [0:0]            w_state_next;
  logic [DATA_WIDTH-1:0] w_sr_next;
  logic [CntW-1:0]       w_cnt_next;
  logic [DATA_WIDTH-1:0] w_hold_next;
  logic                  w_hold_full_next;
  logic [DATA_WIDTH-1:0] w_sr_shifted;
  logic                  w_xfer;
  logic                  w_last;

  assign din_ready = ~r_hold_full;
  assign w_xfer    = din_valid & din_ready;
  assign w_last    = (r_cnt == CntLast);

  assign w_sr_shifted = MSB_FIRST ? {r_sr[DATA_WIDTH-2:0], 1'b0} : {1'b0, r_sr[DATA_WIDTH-1:1]};

  // Outputs depend on registered state only.
  assign busy        = (r_state == StShift);
  assign data_out    = busy & (MSB_FIRST ? r_sr[DATA_WIDTH-1] : r_sr[0]);
  assign frame_start = busy & (r_cnt == '0);

  always_comb begin
    w_state_next     = r_state;
    w_sr_next        = r_sr;
    w_cnt_next       = r_cnt;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_sr_next    = din;
          w_cnt_next   = '0;
          w_state_next = StShift;
        end
      end
      StShift: begin
        if (w_last) begin
          w_cnt_next = '0;
          // A full hold implies din_ready=0, so no transfer can compete with it here.
          if (r_hold_full) begin
            w_sr_next        = r_hold;
            w_hold_full_next = 1'b0;
          end else if (w_xfer) begin
            w_sr_next = din;
          end else begin
            w_sr_next    = '0;
            w_state_next = StIdle;
          end
        end else begin
          w_sr_next  = w_sr_shifted;
          w_cnt_next = r_cnt + 1'b1;
          if (w_xfer) begin
            w_hold_next      = din;
            w_hold_full_next = 1'b1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sr        <= w_sr_next;
      r_cnt       <= w_cnt_next;
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: MSB-first instance for most cases, LSB-first instance for
// bit-order checks; both share stimulus.
module tb_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;

  logic din_ready, data_out, frame_start, busy;
  logic l_din_ready, l_data_out, l_frame_start, l_busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [95:0] cap_bits;
  logic [95:0] cap_fs;
  logic        cap_busy_ok;

  always #5 clk = ~clk;

  serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .data_out   (data_out),
    .frame_start(frame_start),
    .busy       (busy)
  );

  serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (l_din_ready),
    .data_out   (l_data_out),
    .frame_start(l_frame_start),
    .busy       (l_busy)
  );

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a word and returns just after the edge that accepted it.
  task automatic send(input logic [31:0] word);
    int waited;
    din       = word;
    din_valid = 1'b1;
    waited    = 0;
    while (!din_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) check_eq("send_timeout", 96'd0, 96'd1);
    tick();
  endtask

  // Samples n bits, first bit ends up most significant within the low n bits.
  task automatic capture(input int n, input bit lsb_dut);
    cap_bits    = '0;
    cap_fs      = '0;
    cap_busy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      cap_bits = {cap_bits[94:0], lsb_dut ? l_data_out : data_out};
      cap_fs   = {cap_fs[94:0], lsb_dut ? l_frame_start : frame_start};
      if (!(lsb_dut ? l_busy : busy)) cap_busy_ok = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic        bp_ok;
    logic        quiet_ok;

    // 1. Reset with din_valid high: nothing may be accepted.
    rst       = 1'b1;
    din       = 32'hDEAD_BEEF;
    din_valid = 1'b1;
    tick();
    tick();
    check_eq("rst_data_out", {95'd0, data_out}, 96'd0);
    check_eq("rst_busy", {95'd0, busy}, 96'd0);
    check_eq("rst_ready", {95'd0, din_ready}, 96'd1);
    check_eq("rst_fs", {95'd0, frame_start}, 96'd0);
    rst       = 1'b0;
    din_valid = 1'b0;
    tick();
    check_eq("rst_no_xfer", {95'd0, busy}, 96'd0);

    // 2. Single word, MSB first, latency one.
    send(32'h0122_4555);
    din_valid = 1'b0;
    capture(32, 1'b0);
    check_eq("single_bits", cap_bits, {64'd0, 32'h0122_4555});
    check_eq("single_fs", cap_fs, {64'd0, 32'h8000_0000});
    check_eq("single_busy", {95'd0, cap_busy_ok}, 96'd1);
    check_eq("single_idle_busy", {95'd0, busy}, 96'd0);
    check_eq("single_idle_data", {95'd0, data_out}, 96'd0);

    // 3. Three words back-to-back with valid held high.
    send(32'h0122_4555);
    fork
      capture(96, 1'b0);
      begin
        send(32'hCDEF_CDEF);
        send(32'hEDE1_87AF);
        din_valid = 1'b0;
      end
    join
    check_eq("b2b_bits", cap_bits, {32'h0122_4555, 32'hCDEF_CDEF, 32'hEDE1_87AF});
    check_eq("b2b_fs", cap_fs, {32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
    check_eq("b2b_busy", {95'd0, cap_busy_ok}, 96'd1);
    check_eq("b2b_idle", {95'd0, busy}, 96'd0);

    // 4. Backpressure: hold full, din changes must be ignored.
    bp_ok = 1'b1;
    send(32'hCDEF_CDEF);
    fork
      capture(64, 1'b0);
      begin
        send(32'h0122_4555);
        din = 32'hAAAA_5555;
        for (int i = 0; i < 5; i++) begin
          if (din_ready) bp_ok = 1'b0;
          tick();
        end
        din_valid = 1'b0;
      end
    join
    check_eq("bp_ready_low", {95'd0, bp_ok}, 96'd1);
    check_eq("bp_bits", cap_bits, {32'd0, 32'hCDEF_CDEF, 32'h0122_4555});
    check_eq("bp_idle", {95'd0, busy}, 96'd0);

    // 5. Reset at bit 10 with hold full: word and hold discarded.
    send(32'hCDEF_CDEF);
    send(32'h0122_4555);
    din_valid = 1'b0;
    check_eq("mid_hold_full", {95'd0, din_ready}, 96'd0);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_data_out", {95'd0, data_out}, 96'd0);
    check_eq("mid_ready", {95'd0, din_ready}, 96'd1);
    quiet_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (data_out || busy) quiet_ok = 1'b0;
      tick();
    end
    check_eq("mid_no_residue", {95'd0, quiet_ok}, 96'd1);

    // 6. LSB-first instance with a single set bit.
    send(32'h0000_0001);
    din_valid = 1'b0;
    capture(32, 1'b1);
    check_eq("lsb_bits", cap_bits, {64'd0, 32'h8000_0000});
    check_eq("lsb_fs", cap_fs, {64'd0, 32'h8000_0000});
    check_eq("lsb_idle", {95'd0, l_busy}, 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
